jtag_axi_master: RTL

//  AXI4-Lite master that executes one debug bus transaction per JTAG request.

---
 rtl/jtag_axi_master.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/jtag_axi_master.sv
// ============================================================================
// jtag_axi_master : AXI4-Lite master running one bus transaction per JTAG
// update pulse, with transaction status and a saturating abort timer.
// Rev 1.0
// ============================================================================
`default_nettype none

module jtag_axi_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                tck,
  input  logic                trstn,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [2:0]          resp_status,
  output logic                busy,
  output logic                busy_err,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PENDING = 3'd1;
  localparam logic [2:0] ST_OKAY    = 3'd2;
  localparam logic [2:0] ST_TIMEOUT = 3'd6;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;
  logic             aw_ok;
  logic             w_ok;

  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;

  // The timer value at edge k after acceptance is k-1, so matching TO_LAST
  // aborts exactly TIMEOUT_CYC cycles after the request was taken.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (state != IDLE) && (cnt == TO_LAST);
  assign aw_ok       = !m_awvalid || m_awready;
  assign w_ok        = !m_wvalid  || m_wready;

  function automatic logic [2:0] map_resp(input logic [1:0] r);
    return ST_OKAY + {1'b0, r};
  endfunction

  always_ff @(posedge tck) begin
    if (!trstn) begin
      state       <= IDLE;
      cnt         <= '0;
      resp_rdata  <= '0;
      resp_status <= ST_IDLE;
      busy        <= 1'b0;
      busy_err    <= 1'b0;
      m_awaddr    <= '0;
      m_awvalid   <= 1'b0;
      m_wdata     <= '0;
      m_wstrb     <= '0;
      m_wvalid    <= 1'b0;
      m_bready    <= 1'b0;
      m_araddr    <= '0;
      m_arvalid   <= 1'b0;
      m_rready    <= 1'b0;
    end else begin
      if (req_valid && state != IDLE) busy_err <= 1'b1;
      if (state != IDLE && cnt != '1) cnt <= cnt + 1'b1;

      if (timeout_hit) begin
        m_awvalid   <= 1'b0;
        m_wvalid    <= 1'b0;
        m_bready    <= 1'b0;
        m_arvalid   <= 1'b0;
        m_rready    <= 1'b0;
        resp_status <= ST_TIMEOUT;
        busy        <= 1'b0;
        state       <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              busy        <= 1'b1;
              busy_err    <= 1'b0;
              resp_status <= ST_PENDING;
              cnt         <= '0;
              if (req_write) begin
                m_awaddr  <= req_addr;
                m_wdata   <= req_wdata;
                m_wstrb   <= req_wstrb;
                m_awvalid <= 1'b1;
                m_wvalid  <= 1'b1;
                state     <= WR_REQ;
              end else begin
                m_araddr  <= req_addr;
                m_arvalid <= 1'b1;
                state     <= RD_REQ;
              end
            end
          end
          WR_REQ: begin
            if (m_awvalid && m_awready) m_awvalid <= 1'b0;
            if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
            if (aw_ok && w_ok) begin
              m_bready <= 1'b1;
              state    <= WR_RESP;
            end
          end
          WR_RESP: begin
            if (m_bvalid) begin
              m_bready    <= 1'b0;
              resp_status <= map_resp(m_bresp);
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
          RD_REQ: begin
            if (m_arready) begin
              m_arvalid <= 1'b0;
              m_rready  <= 1'b1;
              state     <= RD_RESP;
            end
          end
          RD_RESP: begin
            if (m_rvalid) begin
              m_rready    <= 1'b0;
              resp_rdata  <= m_rdata;
              resp_status <= map_resp(m_rresp);
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
